// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the configuration shift-register sequencer.
//
// Contents:
//   sr_state_t      - sequencer state encoding
//   PHASES_PER_BIT  - phases per shifted bit (SETUP, CK1, GAP, CK2)
//   CNT_W_DEF       - default bit-count width
//   DIV_W_DEF       - default phase-divider width
//   slot_cycles()   - clocks taken by one bit slot for a given divider
package sr_ctrl_pkg;

    localparam int PHASES_PER_BIT = 4;
    localparam int CNT_W_DEF      = 16;
    localparam int DIV_W_DEF      = 8;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        SETUP    = 4'd2,
        CK1      = 4'd3,
        GAP      = 4'd4,
        CK2      = 4'd5,
        GAP_END  = 4'd6,
        LOAD     = 4'd7,
        RB_SETUP = 4'd8,
        RB_CK1   = 4'd9,
        RB_GAP   = 4'd10,
        RB_CK2   = 4'd11,
        DONE     = 4'd12
    } sr_state_t;

    function automatic int unsigned slot_cycles(input int unsigned div_val);
        return PHASES_PER_BIT * (div_val + 1);
    endfunction

endpackage

// File: rtl/sr_config_ctrl_if.sv
// Host-side bundle of the configuration sequencer: transfer request,
// parameters, status and the first-word-fall-through byte FIFO.
//
// Signals:
//   start, abort      - transfer request / immediate termination
//   nbits, div        - bit count and phase divider, latched at start
//   fifo_data         - head byte of the host FIFO
//   fifo_empty        - host FIFO empty
//   fifo_rd_en        - one-cycle pop of the host FIFO
//   busy, done        - transfer in progress / completion pulse
// Modports: master (host side), slave (sequencer side).
interface sr_config_ctrl_if
    import sr_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] nbits;
    logic [DIV_W-1:0] div;
    logic [7:0]       fifo_data;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, nbits, div, fifo_data, fifo_empty,
        input  fifo_rd_en, busy, done
    );

    modport slave (
        input  start, abort, nbits, div, fifo_data, fifo_empty,
        output fifo_rd_en, busy, done
    );
endinterface

// File: rtl/sr_phase_timer.sv
// Phase-length timer: a down-counter reloaded at every phase entry.
// The count sits at zero (its terminal value) until the next load, so a
// phase lasts load_val+1 clocks.
//
// Ports:
//   clock, reset  - system clock, asynchronous active-high reset
//   load          - reload the counter with load_val
//   load_val      - phase length minus one
//   phase_end     - high while the counter is at its terminal value
module sr_phase_timer
    import sr_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             phase_end
);

    logic [DIV_W-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign phase_end = (count_q == '0);

endmodule

// File: rtl/sr_config_ctrl.sv
// Configuration shift-register sequencer. Pulls bytes from the host FIFO
// and shifts them MSB-first into the chip SR using two non-overlapping
// clocks, then strobes the SR load line.
//
// Optional feature: define SR_CTRL_READBACK_EN to add a readback pass of
// nbits clock slots (sr_sin held low) after LOAD, flagged by rb_active.
// Without it the readback states are absent and rb_active is tied low.
//
// Ports:
//   clock, reset      - system clock, asynchronous active-high reset
//   host              - host bundle (slave side of sr_config_ctrl_if)
//   sr_ck1, sr_ck2    - non-overlapping SR clocks (registered)
//   sr_sin            - SR serial data (registered)
//   sr_ld             - SR load strobe (registered)
//   rb_active         - readback pass in progress (registered)
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start
// FETCH    | waiting for / popping the next FIFO byte
// SETUP    | data bit driven, both clocks low
// CK1      | sr_ck1 high
// GAP      | both clocks low between CK1 and CK2
// CK2      | sr_ck2 high; bit retired at phase end
// GAP_END  | settling phase after the last bit
// LOAD     | sr_ld high for one phase
// RB_*     | readback slot phases, sr_sin low (readback build only)
// DONE     | one-cycle completion
module sr_config_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic            clock,
    input  logic            reset,
    sr_config_ctrl_if.slave host,
    output logic            sr_ck1,
    output logic            sr_ck2,
    output logic            sr_sin,
    output logic            sr_ld,
    output logic            rb_active
);

    sr_state_t        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] bits_left_q, bits_left_d;
    logic [7:0]       byte_q, byte_d;
    logic [2:0]       byte_cnt_q, byte_cnt_d;
    logic             pop;
    logic             phase_end;
    logic             timer_load;
    logic             ck1_d, ck2_d, sin_d, ld_d, busy_d, done_d;
    logic             busy_q, done_q;
`ifdef SR_CTRL_READBACK_EN
    logic [CNT_W-1:0] nbits_q, nbits_d;
    logic             rb_d;
`endif

    // Every state change starts a fresh phase; FETCH stalls do not need
    // the timer, so reloading only on a change is sufficient.
    assign timer_load = (state_d != state_q);

    sr_phase_timer #(.DIV_W(DIV_W)) u_phase_timer (
        .clock     (clock),
        .reset     (reset),
        .load      (timer_load),
        .load_val  (div_d),
        .phase_end (phase_end)
    );

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bits_left_d = bits_left_q;
        byte_d      = byte_q;
        byte_cnt_d  = byte_cnt_q;
        pop         = 1'b0;
`ifdef SR_CTRL_READBACK_EN
        nbits_d     = nbits_q;
`endif
        case (state_q)
            IDLE: begin
                if (host.start) begin
                    div_d       = host.div;
                    bits_left_d = host.nbits;
`ifdef SR_CTRL_READBACK_EN
                    nbits_d     = host.nbits;
`endif
                    state_d     = (host.nbits == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (!host.fifo_empty) begin
                    byte_d     = host.fifo_data;
                    byte_cnt_d = 3'd7;
                    pop        = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP:   if (phase_end) state_d = CK1;
            CK1:     if (phase_end) state_d = GAP;
            GAP:     if (phase_end) state_d = CK2;
            CK2: begin
                if (phase_end) begin
                    if (bits_left_q != '0) begin
                        bits_left_d = bits_left_q - 1'b1;
                    end
                    byte_d = {byte_q[6:0], 1'b0};
                    if (bits_left_q <= CNT_W'(1)) begin
                        state_d = GAP_END;
                    end else if (byte_cnt_q == 3'd0) begin
                        state_d = FETCH;
                    end else begin
                        byte_cnt_d = byte_cnt_q - 1'b1;
                        state_d    = SETUP;
                    end
                end
            end
            GAP_END: if (phase_end) state_d = LOAD;
            LOAD: begin
                if (phase_end) begin
`ifdef SR_CTRL_READBACK_EN
                    bits_left_d = nbits_q;
                    state_d     = RB_SETUP;
`else
                    state_d     = DONE;
`endif
                end
            end
`ifdef SR_CTRL_READBACK_EN
            RB_SETUP: if (phase_end) state_d = RB_CK1;
            RB_CK1:   if (phase_end) state_d = RB_GAP;
            RB_GAP:   if (phase_end) state_d = RB_CK2;
            RB_CK2: begin
                if (phase_end) begin
                    if (bits_left_q != '0) begin
                        bits_left_d = bits_left_q - 1'b1;
                    end
                    state_d = (bits_left_q <= CNT_W'(1)) ? DONE : RB_SETUP;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a coincident start or pop.
        if (host.abort) begin
            state_d = IDLE;
            pop     = 1'b0;
        end
    end

    // Pin values are decoded from the next state and registered, so each
    // pin follows its state exactly and never glitches.
    always_comb begin
        ck1_d  = 1'b0;
        ck2_d  = 1'b0;
        ld_d   = 1'b0;
        sin_d  = sr_sin;
`ifdef SR_CTRL_READBACK_EN
        rb_d   = 1'b0;
`endif
        case (state_d)
            SETUP:      sin_d = byte_d[7];
            CK1:        ck1_d = 1'b1;
            CK2:        ck2_d = 1'b1;
            LOAD:       ld_d  = 1'b1;
            IDLE, DONE: sin_d = 1'b0;
`ifdef SR_CTRL_READBACK_EN
            RB_SETUP, RB_GAP: begin
                sin_d = 1'b0;
                rb_d  = 1'b1;
            end
            RB_CK1: begin
                sin_d = 1'b0;
                ck1_d = 1'b1;
                rb_d  = 1'b1;
            end
            RB_CK2: begin
                sin_d = 1'b0;
                ck2_d = 1'b1;
                rb_d  = 1'b1;
            end
`endif
            default: ;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bits_left_q <= '0;
            byte_q      <= '0;
            byte_cnt_q  <= '0;
            sr_ck1      <= 1'b0;
            sr_ck2      <= 1'b0;
            sr_sin      <= 1'b0;
            sr_ld       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bits_left_q <= bits_left_d;
            byte_q      <= byte_d;
            byte_cnt_q  <= byte_cnt_d;
            sr_ck1      <= ck1_d;
            sr_ck2      <= ck2_d;
            sr_sin      <= sin_d;
            sr_ld       <= ld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef SR_CTRL_READBACK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nbits_q   <= '0;
            rb_active <= 1'b0;
        end else begin
            nbits_q   <= nbits_d;
            rb_active <= rb_d;
        end
    end
`else
    assign rb_active = 1'b0;
`endif

    assign host.fifo_rd_en = pop;
    assign host.busy       = busy_q;
    assign host.done       = done_q;

endmodule

// File: tb/tb_sr_config_ctrl.sv
// Testbench for sr_config_ctrl: table of directed transfers plus
// hand-written abort, stall, start-while-busy and reset sequences.
module tb_sr_config_ctrl;

    logic clock = 1'b0;
    logic reset;
    logic sr_ck1, sr_ck2, sr_sin, sr_ld, rb_active;

    sr_config_ctrl_if #(.CNT_W(16), .DIV_W(8)) hif ();

    sr_config_ctrl #(.CNT_W(16), .DIV_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .host      (hif.slave),
        .sr_ck1    (sr_ck1),
        .sr_ck2    (sr_ck2),
        .sr_sin    (sr_sin),
        .sr_ld     (sr_ld),
        .rb_active (rb_active)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          nb;
        int          dv;
        int          nbytes;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] sin;
        int          pops;
        int          ld;
        int          done_c;
        int          ck1hi;
    } vec_t;

    vec_t vecs [5];

    int n_cmp = 0;
    int n_err = 0;
    int t0 = 0;
    logic stall_en = 1'b0;

    // host FIFO model, reloaded on request from the main sequence
    logic [7:0] load_bytes [2];
    int         load_n  = 0;
    int         load_id = 0;
    int         seen_id = 0;
    int         fifo_pops = 0;
    logic       take;
    logic [7:0] fq [$];

    always begin
        @(negedge clock);
        take = hif.fifo_rd_en;
        @(posedge clock);
        #1;
        if (load_id != seen_id) begin
            seen_id = load_id;
            fq.delete();
            for (int i = 0; i < load_n; i++) fq.push_back(load_bytes[i]);
            fifo_pops = 0;
        end else if (take === 1'b1 && fq.size() > 0) begin
            void'(fq.pop_front());
            fifo_pops++;
        end
        hif.fifo_data  = (fq.size() > 0) ? fq[0] : 8'h00;
        hif.fifo_empty = (fq.size() == 0) ||
                         (stall_en && fifo_pops == 1 && (cyc - t0) < 54);
    end

    // monitor state, owned by the main sequence
    logic        mon_en = 1'b0;
    logic        ck1_prev;
    logic [15:0] sin_cap;
    int pairs, rb_pairs, overlap, ck1_hi, rb_cyc, rb_sin_hi, pops;
    int ld_cyc, ld_hi, done_cyc, done_cnt, stall_clk, busy1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        ck1_prev = 1'b0; sin_cap = '0;
        pairs = 0; rb_pairs = 0; overlap = 0; ck1_hi = 0; rb_cyc = 0;
        rb_sin_hi = 0; pops = 0; ld_cyc = -1; ld_hi = 0; done_cyc = -1;
        done_cnt = 0; stall_clk = 0; busy1 = -1;
    endtask

    task automatic sample();
        int r;
        if (!mon_en) return;
        r = cyc - t0;
        if (r == 1) busy1 = int'(hif.busy);
        if (sr_ck1 && sr_ck2) overlap++;
        if (sr_ck1 && !ck1_prev) begin
            if (rb_active) rb_pairs++;
            else begin
                if (pairs < 16) sin_cap[15-pairs] = sr_sin;
                pairs++;
            end
        end
        ck1_prev = sr_ck1;
        if (sr_ck1 && !rb_active) ck1_hi++;
        if (rb_active) begin
            rb_cyc++;
            if (sr_sin) rb_sin_hi++;
        end
        if (hif.fifo_rd_en) pops++;
        if (sr_ld) begin
            ld_hi++;
            if (ld_cyc < 0) ld_cyc = r;
        end
        if (hif.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = r;
        end
        if (stall_en && r >= 34 && r <= 54 && (sr_ck1 || sr_ck2)) stall_clk++;
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
        sample();
    endtask

    task automatic load_fifo(input int n, input logic [7:0] a, input logic [7:0] b);
        load_bytes[0] = a;
        load_bytes[1] = b;
        load_n = n;
        load_id++;
    endtask

    task automatic begin_xfer(input int nb, input int dv);
        clear_mon();
        hif.nbits = nb[15:0];
        hif.div   = dv[7:0];
        hif.start = 1'b1;
        t0 = cyc;
        mon_en = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int inject_rel, input string tag);
        int rbc;
        int exp_done;
        rbc = 0;
`ifdef SR_CTRL_READBACK_EN
        rbc = 4 * v.nb * (v.dv + 1);
`endif
        exp_done = v.done_c + rbc;
        tick();
        load_fifo(v.nbytes, v.b0, v.b1);
        begin_xfer(v.nb, v.dv);
        for (int k = 0; k < exp_done + 20; k++) begin
            tick();
            hif.start = 1'b0;
            if ((cyc - t0) == inject_rel) begin
                hif.start = 1'b1;
                hif.nbits = 16'd0;
            end
            if (done_cyc >= 0 && (cyc - t0) >= done_cyc + 3) break;
        end
        hif.start = 1'b0;
        mon_en = 1'b0;
        chk({tag, "_done_cycle"}, done_cyc, exp_done);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_pairs"}, pairs, v.nb);
        chk({tag, "_sin_seq"}, int'(sin_cap), int'(v.sin));
        chk({tag, "_pops"}, pops, v.pops);
        chk({tag, "_ld_cycle"}, ld_cyc, v.ld);
        chk({tag, "_ld_len"}, ld_hi, (v.nb > 0) ? v.dv + 1 : 0);
        chk({tag, "_ck1_high"}, ck1_hi, v.ck1hi);
        chk({tag, "_overlap"}, overlap, 0);
        chk({tag, "_busy_at1"}, busy1, 1);
        chk({tag, "_busy_after"}, int'(hif.busy), 0);
        chk({tag, "_rb_cycles"}, rb_cyc, rbc);
`ifdef SR_CTRL_READBACK_EN
        chk({tag, "_rb_pairs"}, rb_pairs, v.nb);
        chk({tag, "_rb_sin"}, rb_sin_hi, 0);
`endif
    endtask

    initial begin
        vec_t sv;
        vecs[0] = '{nb: 8,  dv: 0, nbytes: 1, b0: 8'hA5, b1: 8'h00, sin: 16'hA500,
                    pops: 1, ld: 35,  done_c: 36,  ck1hi: 8};
        vecs[1] = '{nb: 12, dv: 3, nbytes: 2, b0: 8'hF0, b1: 8'h3C, sin: 16'hF030,
                    pops: 2, ld: 199, done_c: 203, ck1hi: 48};
        vecs[2] = '{nb: 3,  dv: 1, nbytes: 1, b0: 8'h6F, b1: 8'h00, sin: 16'h6000,
                    pops: 1, ld: 28,  done_c: 30,  ck1hi: 6};
        vecs[3] = '{nb: 9,  dv: 0, nbytes: 2, b0: 8'h01, b1: 8'h80, sin: 16'h0180,
                    pops: 2, ld: 40,  done_c: 41,  ck1hi: 9};
        vecs[4] = '{nb: 0,  dv: 5, nbytes: 0, b0: 8'h00, b1: 8'h00, sin: 16'h0000,
                    pops: 0, ld: -1,  done_c: 1,   ck1hi: 0};

        clear_mon();
        hif.start = 1'b0;
        hif.abort = 1'b0;
        hif.nbits = '0;
        hif.div   = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        tick();
        chk("reset_outputs", int'({sr_ck1, sr_ck2, sr_sin, sr_ld, rb_active,
                                  hif.busy, hif.done, hif.fifo_rd_en}), 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], -1, $sformatf("vec%0d", i));

        // start while busy is ignored
        run_vec(vecs[0], 10, "start_busy");

        // FIFO runs dry after the first byte; second byte arrives at cycle 54
        sv = '{nb: 16, dv: 0, nbytes: 2, b0: 8'hC3, b1: 8'h5A, sin: 16'hC35A,
               pops: 2, ld: 88, done_c: 89, ck1hi: 16};
        stall_en = 1'b1;
        run_vec(sv, -1, "stall");
        chk("stall_clocks_low", stall_clk, 0);
        stall_en = 1'b0;

        // abort in the middle of CK1 of bit 5 (div=3: CK1 spans cycles 86..89)
        tick();
        load_fifo(1, 8'hFF, 8'h00);
        begin_xfer(8, 3);
        for (int k = 0; k < 200 && (cyc - t0) < 87; k++) begin
            tick();
            hif.start = 1'b0;
        end
        chk("abort_reach_cycle", cyc - t0, 87);
        chk("abort_pre_ck1", int'(sr_ck1), 1);
        chk("abort_pre_sin", int'(sr_sin), 1);
        hif.abort = 1'b1;
        tick();
        hif.abort = 1'b0;
        chk("abort_sr_outputs", int'({sr_ck1, sr_ck2, sr_sin, sr_ld}), 0);
        chk("abort_busy", int'(hif.busy), 0);
        repeat (10) tick();
        mon_en = 1'b0;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_pops", pops, 1);
        run_vec(vecs[0], -1, "after_abort");

        // abort coincident with start in IDLE
        tick();
        load_fifo(1, 8'h81, 8'h00);
        begin_xfer(8, 0);
        hif.abort = 1'b1;
        tick();
        hif.start = 1'b0;
        hif.abort = 1'b0;
        chk("abort_start_busy", int'(hif.busy), 0);
        repeat (4) tick();
        mon_en = 1'b0;
        chk("abort_start_pops", pops, 0);
        chk("abort_start_idle", int'({sr_ck1, sr_ck2, sr_ld, hif.busy}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sr_config_ctrl.md
# sr_config_ctrl

Sequencer that shifts configuration bits into the chip's shift register. It drives the two-phase non-overlapping clocks `sr_ck1`/`sr_ck2`, serial data `sr_sin` and the load strobe `sr_ld`. Bits are pulled MSB-first from a host byte FIFO. The block sits between the host configuration FIFO and the chip SR pins, and generates the clocking that the SR readback capture logic samples.

## Interface
Parameters:
- `CNT_W`, 16: width of the bit-count input (max 2^CNT_W−1 bits per transfer)
- `DIV_W`, 8: width of the phase-length divider

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle request to begin a transfer; ignored while `busy`
- `abort`  in  1  terminate the transfer immediately
- `nbits`  in  CNT_W  number of bits to shift; latched at `start`
- `div`  in  DIV_W  each phase lasts `div+1` clocks; latched at `start`
- `fifo_data`  in  8  first-word-fall-through byte from the host FIFO
- `fifo_empty`  in  1  host FIFO empty
- `fifo_rd_en`  out  1  one-cycle pop of the host FIFO
- `sr_ck1`, `sr_ck2`  out  1  non-overlapping SR clocks
- `sr_sin`  out  1  SR serial data
- `sr_ld`  out  1  SR load strobe
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle completion pulse
- `rb_active`  out  1  readback pass in progress (see Configuration)

## Operation
- Reset value of every output and register is 0; the state machine resets to IDLE.
- States: IDLE, FETCH, SETUP, CK1, GAP, CK2, GAP_END, LOAD, RB_SETUP, RB_CK1, RB_GAP, RB_CK2, DONE.
- IDLE: on `start`, latch `nbits` and `div` and set `busy`.
  - If `nbits==0`, go to DONE. No pin activity and no FIFO pop.
  - Otherwise, go to FETCH.
- FETCH: wait while `fifo_empty`; all SR clocks stay low during the stall. When the FIFO is not empty, load `fifo_data` into the byte register, pulse `fifo_rd_en` for one cycle, then go to SETUP.
- SETUP: `sr_sin` = current bit (byte bit 7 first); both clocks low.
- CK1: `sr_ck1`=1.
- GAP: both clocks low.
- CK2: `sr_ck2`=1. At the end of CK2, decrement the remaining-bit count and shift the byte register.
  - If bits remain and the 8th bit of the byte is done, go to FETCH.
  - Else if bits remain, go to SETUP.
  - Else go to GAP_END.
- GAP_END, then LOAD: `sr_ld`=1 for one phase.
- After LOAD, go to RB_SETUP if the readback feature is compiled in; otherwise go to DONE.
- DONE: `done`=1 for one cycle, `busy` cleared, return to IDLE.
- Unused bits of the final byte are discarded; the FIFO is not popped again.
- `abort`, in any state: next cycle goes to IDLE with all SR outputs low and `busy` cleared. No `done` pulse is issued. A byte already popped is lost.
- `start` coincident with `abort` in IDLE: `abort` wins.
- `sr_ck1` and `sr_ck2` are never high in the same cycle. All SR outputs are registered (glitch-free).

## Timing
- Phase length is `div+1` clocks. `div`=0 gives 1-clock phases; `div`=255 gives 256.
- Per bit: 4 phases (SETUP, CK1, GAP, CK2). FETCH is one cycle per byte when the FIFO is non-empty.
- `sr_sin` is stable for a full phase before the `sr_ck1` rise and stays stable through CK2 fall.
- With `start` at cycle 0, `div`=0 and `nbits`=8: FETCH at 1, first SETUP at 2, last CK2 at 33, GAP_END at 34, LOAD at 35, `done` at 36.
- Phase counter and bit counter wrap never: the counters saturate at their terminal values and are reloaded per phase/bit.

## Configuration
- `SR_CTRL_READBACK_EN` defined: after LOAD, run a second pass of `nbits` bit slots (RB_SETUP/RB_CK1/RB_GAP/RB_CK2) with `sr_sin`=0, no FIFO pops and no `sr_ld`. `rb_active`=1 for the whole pass. The pass clocks the SR content out for capture, then the FSM goes to DONE. Extra latency is `4*nbits*(div+1)` cycles.
- Not defined: RB states are not synthesized, `rb_active` is tied to 0, and LOAD goes directly to DONE.

## Structure
- `sr_ctrl_pkg`: the state enum, phase count constant (4), and default `CNT_W`/`DIV_W`.
- Sub-module `sr_phase_timer`: a `DIV_W` down-counter with load input and a `phase_end` pulse output. It is instantiated once.

## Test plan
- `nbits`=8, `div`=0, FIFO holds 0xA5 → `sr_sin` sampled at each `sr_ck1` rise = 1,0,1,0,0,1,0,1; one `fifo_rd_en`; `sr_ld` at cycle 35; `done` at cycle 36.
- `nbits`=12, `div`=3, FIFO holds 0xF0,0x3C → 12 ck1/ck2 pairs, each phase 4 clocks, 2 pops, last 4 bits of 0x3C unused; check ck1/ck2 never overlap.
- FIFO empty after the first byte for 20 cycles with `nbits`=16 → clocks low during the stall, then resume; total `sr_ck1` pulses = 16.
- `abort` asserted mid-CK1 of bit 5 → next cycle all SR outputs 0, `busy`=0, no `done`; a following `start` runs a normal transfer.
- `nbits`=0 → `done` 1 cycle after FETCH-less IDLE exit, no pin toggles; `start` while `busy` → ignored.
- With `SR_CTRL_READBACK_EN`, `nbits`=8, `div`=0 → 8 extra ck1/ck2 pairs with `sr_sin`=0 and `rb_active`=1 for 32 cycles; `done` at cycle 68.
